// File: rtl/serial_frame_deser_pkg.sv
// Shared types and framing constants for the serial frame receiver.
// Any block that decodes or builds these frames imports this package.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Bits needed to count from 0 up to width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_frame_deser_if.sv
// Serial input, handshake and status bundle of the frame receiver.
// The receiver uses the slave modport and its driver uses the master modport.
interface serial_frame_deser_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             bit_in;
    logic             data_ready;
    logic             err_clear;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic             overrun_flag;
    logic [CNT_W-1:0] frame_count;

    modport master (
        output bit_in, data_ready, err_clear,
        input  data_out, data_valid, frame_err, overrun_flag, frame_count
    );

    modport slave (
        input  bit_in, data_ready, err_clear,
        output data_out, data_valid, frame_err, overrun_flag, frame_count
    );
endinterface

// File: rtl/serial_frame_deser_shift_reg.sv
// Right-shift register that assembles the incoming word LSB-first.
// New bits enter at the MSB, so the first data bit ends up at bit 0.
module deser_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_signal,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (shift_en) begin
            shift_d = {bit_in, shift_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_signal or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign word = shift_q;

endmodule

// File: rtl/serial_frame_deser.sv
// Frame receiver: detects start and stop bits, assembles WIDTH data bits and
// hands each good word to a one-entry valid/ready buffer with error flags.
module serial_frame_deser
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic                clk_signal,
    input logic                rst_n,
    serial_frame_deser_if.slave bus
);

    localparam int BIT_CNT_W = cnt_width(WIDTH);

    state_t               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]     data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic [CNT_W-1:0]     frame_count_q, frame_count_d;
    logic                 shift_en;
    logic [WIDTH-1:0]     shift_word;

    deser_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
        .clk_signal (clk_signal),
        .rst_n      (rst_n),
        .shift_en   (shift_en),
        .bit_in     (bus.bit_in),
        .word       (shift_word)
    );

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_en      = 1'b0;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q && !bus.data_ready;
        frame_err_d   = 1'b0;
        // A new overrun in the same cycle as err_clear must win, so it is set below.
        overrun_d     = overrun_q && !bus.err_clear;
        frame_count_d = frame_count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.bit_in != IDLE_LEVEL) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                shift_en  = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_CNT_W'(WIDTH - 1)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                state_d = IDLE;
                if (bus.bit_in == STOP_LEVEL) begin
                    if (!data_valid_q || bus.data_ready) begin
                        data_out_d    = shift_word;
                        data_valid_d  = 1'b1;
                        frame_count_d = frame_count_q + 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_signal or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.overrun_flag = overrun_q;
    assign bus.frame_count  = frame_count_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Self-checking bench for serial_frame_deser: a frame table plus hand-written
// overrun, simultaneous load/consume, mid-frame reset and counter-wrap sequences.
module tb_serial_frame_deser;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    serial_frame_deser_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    serial_frame_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_signal (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_err;
        logic       exp_valid;
    } frame_vec_t;

    frame_vec_t       vecs[8];
    logic [7:0]       sb_q[$];
    logic [CNT_W-1:0] exp_count = '0;
    int               checks    = 0;
    int               errors    = 0;
    logic             held      = 1'b0;
    logic [7:0]       held_word = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] word, input logic stop_bit,
                                 input logic ready_stop, input logic clr_stop);
        bus.bit_in = 1'b0;
        tick();
        for (int i = 0; i < WIDTH; i++) begin
            bus.bit_in = word[i];
            tick();
        end
        bus.bit_in     = stop_bit;
        bus.data_ready = ready_stop;
        bus.err_clear  = clr_stop;
        tick();
        bus.bit_in    = 1'b1;
        bus.err_clear = 1'b0;
    endtask

    // Scoreboard pop on every transfer, plus stability of a stalled word.
    always @(negedge clk) begin
        if (rst_n && held && bus.data_valid) begin
            checkOutput("hold_stable", 32'(bus.data_out), 32'(held_word));
        end
        if (rst_n && bus.data_valid && bus.data_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got 0x%0h expected no word", bus.data_out);
            end else begin
                checkOutput("sb_word", 32'(bus.data_out), 32'(sb_q.pop_front()));
            end
        end
        held      = rst_n && bus.data_valid && !bus.data_ready;
        held_word = bus.data_out;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.bit_in     = 1'b1;
        bus.data_ready = 1'b0;
        bus.err_clear  = 1'b0;

        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_err: 1'b0, exp_valid: 1'b1};
        vecs[1] = '{data: 8'h12, stop_bit: 1'b0, exp_err: 1'b1, exp_valid: 1'b0};
        vecs[2] = '{data: 8'h34, stop_bit: 1'b1, exp_err: 1'b0, exp_valid: 1'b1};
        vecs[3] = '{data: 8'h00, stop_bit: 1'b1, exp_err: 1'b0, exp_valid: 1'b1};
        vecs[4] = '{data: 8'hFF, stop_bit: 1'b1, exp_err: 1'b0, exp_valid: 1'b1};
        vecs[5] = '{data: 8'h01, stop_bit: 1'b1, exp_err: 1'b0, exp_valid: 1'b1};
        vecs[6] = '{data: 8'h80, stop_bit: 1'b1, exp_err: 1'b0, exp_valid: 1'b1};
        vecs[7] = '{data: 8'h6E, stop_bit: 1'b0, exp_err: 1'b1, exp_valid: 1'b0};

        #2 rst_n = 1'b0;
        #10;
        checkOutput("reset_valid", 32'(bus.data_valid), 32'd0);
        checkOutput("reset_data", 32'(bus.data_out), 32'd0);
        checkOutput("reset_err", 32'(bus.frame_err), 32'd0);
        checkOutput("reset_overrun", 32'(bus.overrun_flag), 32'd0);
        checkOutput("reset_count", 32'(bus.frame_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        bus.data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_valid) begin
                sb_q.push_back(vecs[i].data);
                exp_count++;
            end
            applyStimulus(vecs[i].data, vecs[i].stop_bit, 1'b1, 1'b0);
            checkOutput("vec_err", 32'(bus.frame_err), 32'(vecs[i].exp_err));
            checkOutput("vec_valid", 32'(bus.data_valid), 32'(vecs[i].exp_valid));
            checkOutput("vec_count", 32'(bus.frame_count), 32'(exp_count));
            checkOutput("vec_overrun", 32'(bus.overrun_flag), 32'd0);
            tick();
            checkOutput("vec_err_gone", 32'(bus.frame_err), 32'd0);
            checkOutput("vec_valid_gone", 32'(bus.data_valid), 32'd0);
        end

        // Stalled buffer: second word is dropped, then clear vs. set collision.
        bus.data_ready = 1'b0;
        sb_q.push_back(8'h3C);
        exp_count++;
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr_first_valid", 32'(bus.data_valid), 32'd1);
        checkOutput("ovr_first_count", 32'(bus.frame_count), 32'(exp_count));
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr_flag", 32'(bus.overrun_flag), 32'd1);
        checkOutput("ovr_hold_data", 32'(bus.data_out), 32'h3C);
        checkOutput("ovr_count", 32'(bus.frame_count), 32'(exp_count));
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        checkOutput("ovr_cleared", 32'(bus.overrun_flag), 32'd0);
        applyStimulus(8'h77, 1'b1, 1'b0, 1'b1);
        checkOutput("ovr_set_wins", 32'(bus.overrun_flag), 32'd1);
        checkOutput("ovr_still_3c", 32'(bus.data_out), 32'h3C);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear  = 1'b0;
        bus.data_ready = 1'b1;
        tick();
        checkOutput("ovr_drained", 32'(bus.data_valid), 32'd0);
        checkOutput("ovr_clear_again", 32'(bus.overrun_flag), 32'd0);

        // Consume of 0x55 coincides with the stop bit of 0x66.
        bus.data_ready = 1'b0;
        sb_q.push_back(8'h55);
        exp_count++;
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
        checkOutput("swap_first_valid", 32'(bus.data_valid), 32'd1);
        sb_q.push_back(8'h66);
        exp_count++;
        applyStimulus(8'h66, 1'b1, 1'b1, 1'b0);
        checkOutput("swap_valid", 32'(bus.data_valid), 32'd1);
        checkOutput("swap_data", 32'(bus.data_out), 32'h66);
        checkOutput("swap_count", 32'(bus.frame_count), 32'(exp_count));
        checkOutput("swap_overrun", 32'(bus.overrun_flag), 32'd0);
        tick();
        checkOutput("swap_drained", 32'(bus.data_valid), 32'd0);

        // Mid-frame reset with a held word and a sticky overrun pending.
        bus.data_ready = 1'b0;
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_reset_overrun", 32'(bus.overrun_flag), 32'd1);
        bus.bit_in = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.bit_in = ~bus.bit_in;
            tick();
        end
        #2 rst_n = 1'b0;
        bus.bit_in = 1'b1;
        #1;
        checkOutput("abort_valid", 32'(bus.data_valid), 32'd0);
        checkOutput("abort_data", 32'(bus.data_out), 32'd0);
        checkOutput("abort_overrun", 32'(bus.overrun_flag), 32'd0);
        checkOutput("abort_count", 32'(bus.frame_count), 32'd0);
        checkOutput("abort_err", 32'(bus.frame_err), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = '0;
        tick();
        tick();
        bus.data_ready = 1'b1;
        sb_q.push_back(8'h81);
        exp_count++;
        applyStimulus(8'h81, 1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_valid", 32'(bus.data_valid), 32'd1);
        checkOutput("post_reset_data", 32'(bus.data_out), 32'h81);
        checkOutput("post_reset_count", 32'(bus.frame_count), 32'(exp_count));
        tick();

        // Sixteen more good frames: seventeen since reset wraps the counter to 1.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] word;
            word = 8'($urandom_range(0, 255));
            sb_q.push_back(word);
            exp_count++;
            applyStimulus(word, 1'b1, 1'b1, 1'b0);
            checkOutput("wrap_step_count", 32'(bus.frame_count), 32'(exp_count));
            tick();
        end
        checkOutput("wrap_count", 32'(bus.frame_count), 32'd1);

        tick();
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_deser.md
# serial_frame_deser

Serial-to-parallel frame receiver consuming the retimed single-bit stream produced by the positive-edge master-slave flip-flop stage. It detects start/stop framing on the registered bit, assembles WIDTH data bits LSB-first, and presents each completed word through a valid/ready output buffer. It also flags framing errors and overruns, and counts good frames.

## Interface
- WIDTH, 8, data bits per frame (2..16)
- CNT_W, 16, width of good-frame counter
- clk_signal  input  1  single clock, rising edge active
- rst_n  input  1  reset, asynchronous assert, active-low
- bit_in  input  1  retimed serial bit from the upstream flip-flop Q output; one bit per cycle; idle level 1
- data_ready  input  1  downstream accepts data_out when high with data_valid
- err_clear  input  1  synchronous clear of sticky overrun_flag
- data_out  output  WIDTH  assembled word, stable while data_valid is high
- data_valid  output  1  data_out holds an unconsumed word
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun_flag  output  1  sticky: good frame dropped because buffer full
- frame_count  output  CNT_W  good frames accepted into buffer, wraps modulo 2^CNT_W

## Operation
- Reset values: FSM=IDLE, bit counter 0, shift register 0, data_out 0, data_valid 0, frame_err 0, overrun_flag 0, frame_count 0.
- Frame format: start bit 0, then WIDTH data bits LSB-first, then stop bit 1. Total WIDTH+2 cycles.
- FSM states IDLE, DATA, STOP:
  - IDLE: bit_in=0 → DATA, counter cleared. bit_in=1 → stay.
  - DATA: shift bit_in into the MSB end (right shift), counter+1. After WIDTH bits → STOP.
  - STOP, bit_in=1: good frame. Accept into buffer if data_valid=0 or data_ready=1 this cycle; then load data_out, set data_valid=1, frame_count+1. Otherwise drop the word and set overrun_flag. Next state IDLE.
  - STOP, bit_in=0: pulse frame_err, discard word, → IDLE. The 0 is not reinterpreted as a start bit.
- Buffer: data_valid clears when data_ready=1 and no new word loads in the same cycle. Simultaneous consume and load keeps data_valid=1 and shows the new word.
- err_clear=1 clears overrun_flag. If an overrun occurs in the same cycle, set wins.
- frame_count wraps from 2^CNT_W−1 to 0 without a flag.
- Reset mid-frame aborts the frame immediately. Partial bits are discarded, and the buffered word and flags are lost.

## Timing
- Start bit sampled at edge t. Data bits sampled at edges t+1..t+WIDTH. Stop bit sampled at edge t+WIDTH+1.
- data_valid, data_out, frame_count update at edge t+WIDTH+1. frame_err is high for exactly the cycle after edge t+WIDTH+1.
- Latency from start-bit sample to data_valid is WIDTH+1 cycles.
- Back-to-back frames: the next start bit may be sampled at edge t+WIDTH+2 (IDLE), giving a sustained rate of one word per WIDTH+2 cycles.
- Handshake: transfer occurs on a rising edge with data_valid=1 and data_ready=1. data_out must not change while data_valid=1 and data_ready=0.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package serial_frame_pkg:
  - state enum {IDLE, DATA, STOP}
  - constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1
  - function computing the counter width, clog2(WIDTH+1)
- One sub-module, deser_shift_reg: WIDTH-bit right-shift register with shift enable and async active-low reset. The FSM, buffer, flags and counter live in the top.

## Test plan
- WIDTH=8; bit_in stream 1,1,0, then bits of 0xA5 LSB-first, then 1; data_ready=1 → data_valid pulses one cycle with data_out=0xA5, frame_count=1, no errors.
- Two back-to-back frames 0x3C, 0xFF with data_ready=0 throughout → first word 0x3C held and stable, overrun_flag=1 after the second stop bit, frame_count=1. Then err_clear=1 → overrun_flag=0.
- Frame 0x12 with stop bit 0 → frame_err high one cycle, data_valid stays 0, FSM returns to IDLE. A following valid frame 0x34 is received correctly.
- Buffer holding 0x55 with data_ready asserted in the same cycle the stop bit of 0x66 is sampled → data_valid remains 1, data_out=0x66, frame_count incremented, no overrun.
- rst_n driven low asynchronously after 4 data bits of a frame → all outputs 0 immediately. After release, a fresh frame 0x81 is received correctly.
- CNT_W=4; 17 good frames with data_ready=1 → frame_count reads 1 after wrap.
